// File: rtl/inert_pkg.sv
// Shared definitions for the inertial gyro-axis reader.
//   state_t   : reader FSM states
//   NUM_CFG   : number of configuration words written after power-up
//   CFG_TBL   : configuration words, issued in index order
//   GYRO_BASE : register address of the X-axis rate low byte
//   rd_cmd()  : builds the SPI read word for byte slot idx (X_L, X_H, Y_L, ...)
package inert_pkg;

  typedef enum logic [2:0] {
    PWRUP    = 3'd0,
    CFG      = 3'd1,
    WAIT_INT = 3'd2,
    RD       = 3'd3,
    VLD      = 3'd4
  } state_t;

  localparam int          NUM_CFG   = 3;
  localparam logic [6:0]  GYRO_BASE = 7'h22;
  localparam logic [15:0] CFG_TBL [NUM_CFG] = '{16'h0D02, 16'h1160, 16'h1440};

  // Byte slots are laid out contiguously from GYRO_BASE, so slot idx
  // lives at GYRO_BASE+idx. Bit 15 set marks a read.
  function automatic logic [15:0] rd_cmd(input logic [2:0] idx);
    logic [6:0] addr;
    addr = GYRO_BASE + {4'b0000, idx};
    return {1'b1, addr, 8'h00};
  endfunction

endpackage

// File: rtl/inert_axis_rdr.sv
// Inertial sensor gyro reader. After a power-up delay it writes the
// configuration table over SPI, then on every data-ready (INT) it reads the
// low/high bytes of NUM_AXES gyro axes and publishes them atomically.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   INT         : sensor data-ready, asynchronous (synchronised internally)
//   done        : SPI monarch transaction-complete pulse
//   rd_data     : SPI monarch read word, byte in [7:0]
//   wrt, cmd    : start an SPI transaction with word cmd (cmd is 0 when idle)
//   rates       : signed rates, axis k at [16k+15:16k]
//   vld         : one-cycle pulse while rates holds a fresh sample set
//   ovr_cnt     : saturating count of INT events that arrived while busy
//   err         : sticky SPI timeout flag
//   state_dbg   : current FSM state, for observation only
//
// SPI handshake: wrt is a single-cycle request carrying cmd in that same
// cycle; the monarch answers with a single-cycle done (read byte valid in
// rd_data during done). Only one transaction is outstanding at a time, and
// the follow-on request is issued combinationally in the done cycle.
module inert_axis_rdr
  import inert_pkg::*;
#(
  parameter int NUM_AXES = 3,
  parameter int PWRUP_W  = 16,
  parameter int TMO_CYC  = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    INT,
  input  logic                    done,
  input  logic [15:0]             rd_data,
  output logic                    wrt,
  output logic [15:0]             cmd,
  output logic [16*NUM_AXES-1:0]  rates,
  output logic                    vld,
  output logic [7:0]              ovr_cnt,
  output logic                    err,
  output state_t                  state_dbg
);

  localparam int NUM_RD = 2 * NUM_AXES;
  localparam int TMO_W  = $clog2(TMO_CYC) + 1;

  state_t                 state, state_nxt;
  logic                   int_meta, int_s, int_s_q;
  logic [PWRUP_W-1:0]     pwr_cnt;
  logic [1:0]             cfg_idx, cfg_idx_nxt;
  logic [2:0]             rd_idx, rd_idx_nxt;
  logic [TMO_W-1:0]       tmo_cnt;
  logic                   tmo_hit;
  logic                   in_xfer;
  logic [16*NUM_AXES-1:0] shadow, shadow_cap;
  logic                   cap, load_rates, to_evt;
  logic                   int_rise;

  assign state_dbg = state;
  assign vld       = (state == VLD);
  assign in_xfer   = (state == CFG) || (state == RD);
  assign tmo_hit   = (tmo_cnt == TMO_W'(TMO_CYC - 1));
  assign int_rise  = int_s && !int_s_q;

  // Shadow with the byte of the current done merged into its slot.
  always_comb begin
    shadow_cap = shadow;
    for (int b = 0; b < NUM_RD; b++) begin
      if (rd_idx == 3'(b)) shadow_cap[8*b +: 8] = rd_data[7:0];
    end
  end

  // Next-state and Mealy outputs (wrt/cmd react to done in the same cycle).
  always_comb begin
    state_nxt   = state;
    wrt         = 1'b0;
    cmd         = 16'h0000;
    cfg_idx_nxt = cfg_idx;
    rd_idx_nxt  = rd_idx;
    cap         = 1'b0;
    load_rates  = 1'b0;
    to_evt      = 1'b0;
    case (state)
      PWRUP: begin
        if (&pwr_cnt) begin
          wrt         = 1'b1;
          cmd         = CFG_TBL[0];
          cfg_idx_nxt = 2'd1;
          state_nxt   = CFG;
        end
      end
      CFG: begin
        if (done) begin
          if (cfg_idx < 2'(NUM_CFG)) begin
            wrt         = 1'b1;
            cmd         = CFG_TBL[cfg_idx];
            cfg_idx_nxt = cfg_idx + 2'd1;
          end else begin
            state_nxt = WAIT_INT;
          end
        end else if (tmo_hit) begin
          to_evt    = 1'b1;
          state_nxt = PWRUP;
        end
      end
      WAIT_INT: begin
        if (int_s) begin
          wrt        = 1'b1;
          cmd        = rd_cmd(3'd0);
          rd_idx_nxt = 3'd0;
          state_nxt  = RD;
        end
      end
      RD: begin
        if (done) begin
          cap = 1'b1;
          if (rd_idx == 3'(NUM_RD - 1)) begin
            load_rates = 1'b1;
            state_nxt  = VLD;
          end else begin
            wrt        = 1'b1;
            cmd        = rd_cmd(rd_idx + 3'd1);
            rd_idx_nxt = rd_idx + 3'd1;
          end
        end else if (tmo_hit) begin
          to_evt    = 1'b1;
          state_nxt = PWRUP;
        end
      end
      VLD: begin
        state_nxt = WAIT_INT;
      end
      default: begin
        state_nxt = PWRUP;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PWRUP;
      int_meta <= 1'b0;
      int_s    <= 1'b0;
      int_s_q  <= 1'b0;
      pwr_cnt  <= '0;
      cfg_idx  <= 2'd0;
      rd_idx   <= 3'd0;
      tmo_cnt  <= '0;
      shadow   <= '0;
      rates    <= '0;
      ovr_cnt  <= 8'h00;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      int_meta <= INT;
      int_s    <= int_meta;
      int_s_q  <= int_s;
      cfg_idx  <= cfg_idx_nxt;
      rd_idx   <= rd_idx_nxt;

      // Held at zero outside PWRUP so any re-entry gets the full delay.
      if (state == PWRUP) pwr_cnt <= pwr_cnt + 1'b1;
      else                pwr_cnt <= '0;

      // Counts idle cycles of the outstanding transaction only.
      if (wrt || !in_xfer) tmo_cnt <= '0;
      else if (!tmo_hit)   tmo_cnt <= tmo_cnt + 1'b1;

      // rates is loaded on the final byte so it is already fresh in the
      // VLD cycle where vld is high; partial sets never reach rates.
      if (to_evt)   shadow <= '0;
      else if (cap) shadow <= shadow_cap;
      if (load_rates) rates <= shadow_cap;

      if (to_evt) err <= 1'b1;

      // Busy means mid-read or publishing; edges there are lost samples.
      if (int_rise && (state == RD || state == VLD) && ovr_cnt != 8'hFF)
        ovr_cnt <= ovr_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_inert_axis_rdr.sv
module tb_inert_axis_rdr;
  import inert_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT with 3 axes ----------------
  logic        int3, done3, wrt3, vld3, err3;
  logic [15:0] rd_data3, cmd3;
  logic [47:0] rates3;
  logic [7:0]  ovr3;
  state_t      st3;

  inert_axis_rdr #(.NUM_AXES(3), .PWRUP_W(9), .TMO_CYC(64)) dut3 (
    .clk(clk), .rst_n(rst_n), .INT(int3), .done(done3), .rd_data(rd_data3),
    .wrt(wrt3), .cmd(cmd3), .rates(rates3), .vld(vld3), .ovr_cnt(ovr3),
    .err(err3), .state_dbg(st3)
  );

  // ---------------- DUT with 1 axis ----------------
  logic        int1, done1, wrt1, vld1, err1;
  logic [15:0] rd_data1, cmd1;
  logic [15:0] rates1;
  logic [7:0]  ovr1;
  state_t      st1;

  inert_axis_rdr #(.NUM_AXES(1), .PWRUP_W(9), .TMO_CYC(64)) dut1 (
    .clk(clk), .rst_n(rst_n), .INT(int1), .done(done1), .rd_data(rd_data1),
    .wrt(wrt1), .cmd(cmd1), .rates(rates1), .vld(vld1), .ovr_cnt(ovr1),
    .err(err1), .state_dbg(st1)
  );

  // ---------------- scoreboard state ----------------
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [15:0] log3[$];
  logic [15:0] log1[$];
  logic [15:0] hold3 = 16'hFFFF;
  logic [7:0]  byte_tbl [6] = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h80};
  logic [15:0] exp_cfg  [3] = '{16'h0D02, 16'h1160, 16'h1440};
  logic [15:0] exp_rd   [6] = '{16'hA200, 16'hA300, 16'hA400, 16'hA500, 16'hA600, 16'hA700};

  // Sensor model: byte for a read address, junk in the upper byte.
  function automatic logic [15:0] resp(input logic [15:0] c);
    int a;
    if (!c[15]) return 16'h5A00;
    a = int'(c[14:8]) - 'h22;
    if (a >= 0 && a < 6) return {8'h5A, byte_tbl[a]};
    return 16'h5A00;
  endfunction

  // ---------------- SPI monarch drivers (done 20 cycles after wrt) ----------------
  initial begin
    logic [15:0] c;
    done3 = 1'b0; rd_data3 = 16'h0000;
    forever begin
      @(negedge clk); done3 = 1'b0; #1;
      while (wrt3) begin
        log3.push_back(cmd3);
        if (cmd3 == hold3) break;
        c = cmd3;
        repeat (20) begin @(negedge clk); done3 = 1'b0; end
        rd_data3 = resp(c); done3 = 1'b1; #1;
      end
    end
  end

  initial begin
    logic [15:0] c;
    done1 = 1'b0; rd_data1 = 16'h0000;
    forever begin
      @(negedge clk); done1 = 1'b0; #1;
      while (wrt1) begin
        log1.push_back(cmd1);
        c = cmd1;
        repeat (20) begin @(negedge clk); done1 = 1'b0; end
        rd_data1 = resp(c); done1 = 1'b1; #1;
      end
    end
  end

  task automatic tick();
    @(negedge clk); #2;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; int3 = 1'b0; int1 = 1'b0;
    repeat (3) tick();
    n_chk++;
    if ({wrt3, cmd3, vld3, err3, ovr3} !== 27'h0)
      $display("FAIL reset_out3: wrt=%b cmd=%h vld=%b err=%b ovr=%h want all 0", wrt3, cmd3, vld3, err3, ovr3);
    else n_pass++;
    n_chk++;
    if (rates3 !== 48'h0) $display("FAIL reset_rates3: got %h want 0", rates3);
    else n_pass++;
    n_chk++;
    if (st3 !== PWRUP || st1 !== PWRUP) $display("FAIL reset_state: got %0d/%0d want PWRUP", st3, st1);
    else n_pass++;
    n_chk++;
    if ({wrt1, cmd1, rates1, vld1, err1, ovr1} !== 43'h0)
      $display("FAIL reset_out1: wrt=%b cmd=%h rates=%h want all 0", wrt1, cmd1, rates1);
    else n_pass++;
  endtask

  task automatic test_pwrup_cfg();
    int n;
    log3.delete(); log1.delete();
    rst_n = 1'b1;
    n = 0;
    while (!wrt3 && n < 2000) begin tick(); n++; end
    n_chk++;
    if (n != 511 || cmd3 !== 16'h0D02)
      $display("FAIL pwrup_first_wrt: cycle=%0d cmd=%h want cycle 511 cmd 0d02", n, cmd3);
    else n_pass++;
    n_chk++;
    if (wrt1 !== 1'b1 || cmd1 !== 16'h0D02)
      $display("FAIL pwrup_first_wrt1: wrt=%b cmd=%h want 1/0d02", wrt1, cmd1);
    else n_pass++;
    tick(); n++;
    n_chk++;
    if (wrt3 !== 1'b0 || cmd3 !== 16'h0000)
      $display("FAIL wrt_one_cycle: wrt=%b cmd=%h want 0/0000", wrt3, cmd3);
    else n_pass++;
    while (st3 != WAIT_INT && n < 2000) begin tick(); n++; end
    n_chk++;
    if (n != 572) $display("FAIL cfg_to_wait_int: cycle=%0d want 572", n);
    else n_pass++;
    n_chk++;
    if (log3.size() != 3 || log3[0] !== exp_cfg[0] || log3[1] !== exp_cfg[1] || log3[2] !== exp_cfg[2])
      $display("FAIL cfg_cmds: got %p want 0d02,1160,1440", log3);
    else n_pass++;
    n_chk++;
    if (st1 !== WAIT_INT || log1.size() != 3)
      $display("FAIL cfg_dut1: state=%0d cmds=%0d want WAIT_INT/3", st1, log1.size());
    else n_pass++;
  endtask

  task automatic test_read3();
    int n;
    bit ok;
    int vlds;
    log3.delete();
    int3 = 1'b1;
    n = 0;
    while (!vld3 && n < 1000) begin
      tick(); n++;
      if (n == 2) int3 = 1'b0;
    end
    n_chk++;
    if (n != 123) $display("FAIL read3_vld_time: cycle=%0d want 123", n);
    else n_pass++;
    n_chk++;
    if (rates3 !== 48'h8001_ABCD_1234) $display("FAIL read3_rates: got %h want 8001abcd1234", rates3);
    else n_pass++;
    ok = (log3.size() == 6);
    for (int i = 0; i < 6 && ok; i++) if (log3[i] !== exp_rd[i]) ok = 0;
    n_chk++;
    if (!ok) $display("FAIL read3_cmds: got %p want a200..a700", log3);
    else n_pass++;
    vlds = 0;
    repeat (30) begin tick(); if (vld3) vlds++; end
    n_chk++;
    if (vlds != 0 || st3 !== WAIT_INT)
      $display("FAIL read3_single_vld: extra vld=%0d state=%0d want 0/WAIT_INT", vlds, st3);
    else n_pass++;
  endtask

  task automatic test_read1();
    int n;
    log1.delete();
    int1 = 1'b1;
    n = 0;
    while (!vld1 && n < 1000) begin
      tick(); n++;
      if (n == 2) int1 = 1'b0;
    end
    n_chk++;
    if (n != 43) $display("FAIL read1_vld_time: cycle=%0d want 43", n);
    else n_pass++;
    n_chk++;
    if (rates1 !== 16'h1234) $display("FAIL read1_rates: got %h want 1234", rates1);
    else n_pass++;
    n_chk++;
    if (log1.size() != 2 || log1[0] !== 16'hA200 || log1[1] !== 16'hA300)
      $display("FAIL read1_cmds: got %p want a200,a300", log1);
    else n_pass++;
  endtask

  task automatic test_ovr();
    int n;
    int3 = 1'b1;
    n = 0;
    while (!vld3 && n < 1000) begin
      tick(); n++;
      // start pulse, then three 2-high/2-low pulses while the read runs
      case (n)
        2, 12, 16, 20: int3 = 1'b0;
        10, 14, 18:    int3 = 1'b1;
        default: ;
      endcase
    end
    n_chk++;
    if (ovr3 !== 8'd3) $display("FAIL ovr_three: got %0d want 3", ovr3);
    else n_pass++;
    n_chk++;
    if (rates3 !== 48'h8001_ABCD_1234) $display("FAIL ovr_rates: got %h want 8001abcd1234", rates3);
    else n_pass++;
  endtask

  task automatic test_ovr_sat();
    int n;
    for (int p = 0; p < 300; p++) begin
      int3 = 1'b1; tick(); tick();
      int3 = 1'b0; tick(); tick();
    end
    repeat (5) tick();
    n = 0;
    while (st3 != WAIT_INT && n < 400) begin tick(); n++; end
    n_chk++;
    if (ovr3 !== 8'hFF || st3 !== WAIT_INT)
      $display("FAIL ovr_saturate: got %h state=%0d want ff/WAIT_INT", ovr3, st3);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int n;
    bit  saw_vld;
    hold3 = 16'hA300;
    int3  = 1'b1;
    n = 0;
    saw_vld = 0;
    while (!(wrt3 && cmd3 == 16'hA300) && n < 200) begin
      tick(); n++;
      if (n == 2) int3 = 1'b0;
    end
    n_chk++;
    if (n != 22) $display("FAIL tmo_xh_wrt: cycle=%0d want 22", n);
    else n_pass++;
    repeat (64) begin tick(); if (vld3) saw_vld = 1; end
    n_chk++;
    if (err3 !== 1'b0 || st3 !== RD)
      $display("FAIL tmo_before: err=%b state=%0d want 0/RD", err3, st3);
    else n_pass++;
    tick();
    n_chk++;
    if (err3 !== 1'b1 || st3 !== PWRUP || saw_vld)
      $display("FAIL tmo_fire: err=%b state=%0d vld_seen=%b want 1/PWRUP/0", err3, st3, saw_vld);
    else n_pass++;
    n_chk++;
    if (rates3 !== 48'h8001_ABCD_1234) $display("FAIL tmo_rates_kept: got %h want 8001abcd1234", rates3);
    else n_pass++;
    hold3 = 16'hFFFF;
    n = 0;
    while (st3 != WAIT_INT && n < 2000) begin tick(); n++; end
    n_chk++;
    if (n != 572 || err3 !== 1'b1)
      $display("FAIL tmo_reinit: cycle=%0d err=%b want 572/1", n, err3);
    else n_pass++;
  endtask

  task automatic test_reset_mid_rd();
    int  n;
    bit  saw_vld;
    int3 = 1'b1;
    tick(); tick();
    int3 = 1'b0;
    repeat (40) tick();
    n_chk++;
    if (st3 !== RD) $display("FAIL mid_rd_setup: state=%0d want RD", st3);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({wrt3, cmd3, vld3, err3, ovr3} !== 27'h0 || rates3 !== 48'h0 || st3 !== PWRUP)
      $display("FAIL mid_rd_reset: wrt=%b cmd=%h vld=%b err=%b ovr=%h rates=%h want all 0",
               wrt3, cmd3, vld3, err3, ovr3, rates3);
    else n_pass++;
    tick(); tick();
    log3.delete();
    rst_n = 1'b1;
    n = 0;
    saw_vld = 0;
    while (!wrt3 && n < 2000) begin tick(); n++; if (vld3) saw_vld = 1; end
    n_chk++;
    if (n != 511 || cmd3 !== 16'h0D02)
      $display("FAIL reinit_first_wrt: cycle=%0d cmd=%h want 511/0d02", n, cmd3);
    else n_pass++;
    while (st3 != WAIT_INT && n < 2000) begin tick(); n++; if (vld3) saw_vld = 1; end
    n_chk++;
    if (n != 572 || saw_vld || rates3 !== 48'h0)
      $display("FAIL reinit_done: cycle=%0d vld_seen=%b rates=%h want 572/0/0", n, saw_vld, rates3);
    else n_pass++;
    n_chk++;
    if (log3.size() != 3 || log3[0] !== exp_cfg[0] || log3[1] !== exp_cfg[1] || log3[2] !== exp_cfg[2])
      $display("FAIL reinit_cmds: got %p want 0d02,1160,1440", log3);
    else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_pwrup_cfg();
    test_read3();
    test_read1();
    test_ovr();
    test_ovr_sat();
    test_timeout();
    test_reset_mid_rd();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
